// File: rtl/dmem_responder.sv
// Data-memory responder: services one load/store at a time with a fixed latency,
// byte strobes and alignment/range error reporting over valid/ready channels.
module dmem_responder #(
    parameter int unsigned WORD        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD-1:0]   req_addr,
    input  logic [WORD-1:0]   req_wdata,
    input  logic [WORD/8-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int unsigned NB = WORD / 8;
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WORD-1:0] DepthW = WORD'(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q;
    logic [WORD-1:0] addr_q, wdata_q;
    logic [NB-1:0]   wstrb_q;
    logic [WORD-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [WORD-1:0] mem [DEPTH_WORDS];

    logic            accept, exec;
    logic            ex_write, ex_err;
    logic [WORD-1:0] ex_addr, ex_wdata;
    logic [NB-1:0]   ex_wstrb;
    logic [AW-1:0]   ex_idx;

    assign req_ready  = (state_q == StIdle) && reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // With LATENCY==1 the execute edge is the accept edge, so operands bypass the latches.
    assign ex_write = (state_q == StIdle) ? req_write : write_q;
    assign ex_addr  = (state_q == StIdle) ? req_addr  : addr_q;
    assign ex_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
    assign ex_wstrb = (state_q == StIdle) ? req_wstrb : wstrb_q;
    assign ex_err   = (ex_addr[1:0] != 2'b00) || ({2'b00, ex_addr[WORD-1:2]} >= DepthW);
    assign ex_idx   = ex_addr[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        exec    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        exec    = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    exec    = 1'b1;
                    state_d = StResp;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (exec) begin
            err_d   = ex_err;
            rdata_d = (ex_err || ex_write) ? '0 : mem[ex_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    // Storage is never cleared; a reset edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (reset && exec && ex_write && !ex_err) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (ex_wstrb[i]) mem[ex_idx][8*i +: 8] <= ex_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances (latency 2, 3, 1, 15) checked against a
// word-array model through a response scoreboard.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [4];
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready;
    logic        rr [4];
    logic        rv [4];
    logic [31:0] rd [4];
    logic        er [4];

    int          lat_tab [4] = '{2, 3, 1, 15};
    logic [31:0] model [4][1024];
    logic [32:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WORD(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(rr[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(rv[0]), .resp_ready(resp_ready),
        .resp_rdata(rd[0]), .resp_err(er[0]));
    dmem_responder #(.WORD(32), .DEPTH_WORDS(1024), .LATENCY(3)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(rr[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(rv[1]), .resp_ready(resp_ready),
        .resp_rdata(rd[1]), .resp_err(er[1]));
    dmem_responder #(.WORD(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(rr[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(rv[2]), .resp_ready(resp_ready),
        .resp_rdata(rd[2]), .resp_err(er[2]));
    dmem_responder #(.WORD(32), .DEPTH_WORDS(1024), .LATENCY(15)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid[3]), .req_ready(rr[3]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(rv[3]), .resp_ready(resp_ready),
        .resp_rdata(rd[3]), .resp_err(er[3]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request on instance k, hold resp_ready low for 'hold' cycles, then complete it.
    task automatic do_req(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                          output logic [31:0] got);
        logic        err;
        logic [31:0] exp_d, r0;
        logic [32:0] exp_e;
        logic        e0;
        int          c;
        bit          seen;
        err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd1024);
        if (!err && wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[k][addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
        end
        exp_d = (err || wr) ? 32'h0 : model[k][addr[11:2]];
        sb_q.push_back({err, exp_d});
        got = 32'h0;
        @(negedge clk);
        check_eq("req_ready_idle", rr[k], 1'b1);
        req_valid[k] = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wdata;
        req_wstrb    = strb;
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            seen = rv[k];
        end
        check_eq("latency", c, lat_tab[k]);
        exp_e = sb_q.pop_front();
        if (!seen) return;
        r0 = rd[k];
        e0 = er[k];
        for (int h = 0; h < hold; h++) begin
            if (h > 0) @(negedge clk);
            check_eq("bp_valid", rv[k], 1'b1);
            check_eq("bp_rdata", rd[k], r0);
            check_eq("bp_err", er[k], e0);
            check_eq("bp_req_ready", rr[k], 1'b0);
            if (h == 1) begin
                req_valid[k] = 1'b1;
                req_write    = 1'b1;
                req_wdata    = 32'hFFFF_FFFF;
                req_wstrb    = 4'hF;
            end else begin
                req_valid[k] = 1'b0;
            end
        end
        if (hold > 0) @(negedge clk);
        req_valid[k] = 1'b0;
        resp_ready   = 1'b1;
        check_eq("resp_valid", rv[k], 1'b1);
        check_eq("resp_err", er[k], exp_e[32]);
        check_eq("resp_rdata", rd[k], exp_e[31:0]);
        got = rd[k];
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check_eq("post_valid", rv[k], 1'b0);
        check_eq("post_req_ready", rr[k], 1'b1);
        check_eq("post_rdata", rd[k], 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        reset      = 1'b0;
        resp_ready = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        for (int k = 0; k < 4; k++) req_valid[k] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_req_ready", rr[k], 1'b0);
            check_eq("rst_resp_valid", rv[k], 1'b0);
            check_eq("rst_rdata", rd[k], 32'h0);
            check_eq("rst_err", er[k], 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", rr[0], 1'b1);

        // Store/load and strobes, latency 2
        do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, got);
        check_eq("store_rdata", got, 32'h0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        check_eq("load_full", got, 32'hDEAD_BEEF);
        do_req(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, got);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        check_eq("load_strb", got, 32'hDE22_BE44);
        do_req(0, 1'b1, 32'h10, 32'h5555_5555, 4'h0, 0, got);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        check_eq("load_nostrb", got, 32'hDE22_BE44);

        // Errors
        do_req(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, got);
        do_req(0, 1'b1, 32'h0, 32'hA5A5_0001, 4'hF, 0, got);
        do_req(0, 1'b1, 32'h1000, 32'h7777_7777, 4'hF, 0, got);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, got);
        check_eq("load_after_err", got, 32'hA5A5_0001);

        // Back-pressure with an ignored request pulse
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, got);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        check_eq("bp_no_store", got, 32'hDE22_BE44);

        // Random traffic over a preloaded window
        for (int i = 0; i < 16; i++)
            do_req(0, 1'b1, 32'h40 + 32'(4 * i), $urandom, 4'hF, 0, got);
        for (int i = 0; i < 12; i++) begin
            a = 32'h40 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) a = a + 32'd2;
            do_req(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0, got);
        end

        // Reset mid-WAIT, latency 3
        do_req(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, got);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write    = 1'b1;
        req_addr     = 32'h20;
        req_wdata    = 32'hCAFE_F00D;
        req_wstrb    = 4'hF;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("mid_rst_valid", rv[1], 1'b0);
            check_eq("mid_rst_rdata", rd[1], 32'h0);
            check_eq("mid_rst_err", er[1], 1'b0);
            check_eq("mid_rst_ready", rr[1], 1'b0);
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("no_spurious", rv[1], 1'b0);
        end
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, got);
        check_eq("dropped_store", got, 32'h1234_5678);

        // Latency extremes
        do_req(2, 1'b1, 32'h8, 32'h0BAD_CAFE, 4'hF, 0, got);
        do_req(2, 1'b0, 32'h8, 32'h0, 4'h0, 0, got);
        do_req(2, 1'b0, 32'hFFC, 32'h0, 4'h0, 0, got);
        do_req(3, 1'b1, 32'hFFC, 32'h8765_4321, 4'b1001, 0, got);
        do_req(3, 1'b0, 32'hFFC, 32'h0, 4'h0, 0, got);
        do_req(3, 1'b0, 32'h3, 32'h0, 4'h0, 2, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
